// File: rtl/cache_ctrl_fsm_if.sv
// Requester/memory-side signal bundle for the cache miss controller.
// The controller sits on the slave modport; the requester/memory model drives the master side.
interface cache_ctrl_fsm_if #(
    parameter int WORDS = 4
);
    localparam int OFFW = $clog2(WORDS);

    logic            rd;
    logic            wr;
    logic            hit;
    logic            valid;
    logic            dirty;
    logic            mem_stall;
    logic            stall;
    logic            done;
    logic            err;
    logic            cache_hit;
    logic            cache_wr;
    logic            comp;
    logic            cache_sel;
    logic [OFFW-1:0] cache_offset;
    logic            mem_wr;
    logic            mem_rd;
    logic            mem_sel;
    logic [OFFW-1:0] mem_offset;

    modport slave (
        input  rd, wr, hit, valid, dirty, mem_stall,
        output stall, done, err, cache_hit, cache_wr, comp, cache_sel,
               cache_offset, mem_wr, mem_rd, mem_sel, mem_offset
    );

    modport master (
        output rd, wr, hit, valid, dirty, mem_stall,
        input  stall, done, err, cache_hit, cache_wr, comp, cache_sel,
               cache_offset, mem_wr, mem_rd, mem_sel, mem_offset
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Cache miss controller: hit completion in IDLE, dirty-line writeback, pipelined line
// allocation overlapping memory reads with cache fills, then compare and done.
module cache_ctrl_fsm #(
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_ctrl_fsm_if.slave       io_bus,
    output logic [2:0]            o_dbg_state
);
    localparam int OFFW = $clog2(WORDS);
    localparam int CNTW = $clog2(WORDS + MEM_LAT);

    localparam logic [CNTW-1:0] C_LAST_WB = CNTW'(WORDS - 1);
    localparam logic [CNTW-1:0] C_LAST_AL = CNTW'(WORDS + MEM_LAT - 1);
    localparam logic [CNTW-1:0] C_WORDS   = CNTW'(WORDS);
    localparam logic [CNTW-1:0] C_LAT     = CNTW'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_ALLOC = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_wr_q;

    logic            w_one_req;
    logic            w_both_req;
    logic            w_hit;
    logic            w_stall, w_done, w_err, w_cache_hit, w_cache_wr, w_comp, w_cache_sel;
    logic            w_mem_wr, w_mem_rd, w_mem_sel;
    logic [OFFW-1:0] w_cache_offset, w_mem_offset;

    assign w_one_req  = io_bus.rd ^ io_bus.wr;
    assign w_both_req = io_bus.rd & io_bus.wr;
    assign w_hit      = io_bus.hit & io_bus.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr_q  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_one_req && !w_hit) begin
                        r_wr_q  <= io_bus.wr;
                        r_cnt   <= '0;
                        r_state <= (io_bus.valid && io_bus.dirty) ? S_WB : S_ALLOC;
                    end
                end
                S_WB: begin
                    if (!io_bus.mem_stall) begin
                        if (r_cnt == C_LAST_WB) begin
                            r_cnt   <= '0;
                            r_state <= S_ALLOC;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                // A stall freezes cnt, which also freezes the read-to-fill alignment.
                S_ALLOC: begin
                    if (!io_bus.mem_stall) begin
                        if (r_cnt == C_LAST_AL) begin
                            r_cnt   <= '0;
                            r_state <= S_CMP;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                S_CMP:   r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall        = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_cache_hit    = 1'b0;
        w_cache_wr     = 1'b0;
        w_comp         = 1'b0;
        w_cache_sel    = 1'b0;
        w_cache_offset = '0;
        w_mem_wr       = 1'b0;
        w_mem_rd       = 1'b0;
        w_mem_sel      = 1'b0;
        w_mem_offset   = '0;
        if (rst) begin
            w_comp = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_both_req) begin
                        w_err = 1'b1;
                    end else if (w_one_req) begin
                        if (w_hit) begin
                            w_done      = 1'b1;
                            w_cache_hit = 1'b1;
                            w_cache_wr  = io_bus.wr;
                            w_comp      = 1'b1;
                        end
                    end else begin
                        w_comp = 1'b1;
                    end
                end
                S_WB: begin
                    w_stall        = 1'b1;
                    w_mem_wr       = 1'b1;
                    w_cache_sel    = 1'b1;
                    w_cache_offset = r_cnt[OFFW-1:0];
                    w_mem_offset   = r_cnt[OFFW-1:0];
                end
                S_ALLOC: begin
                    w_stall = 1'b1;
                    if (r_cnt < C_WORDS) begin
                        w_mem_rd     = 1'b1;
                        w_mem_sel    = 1'b1;
                        w_mem_offset = r_cnt[OFFW-1:0];
                    end
                    if (r_cnt >= C_LAT) begin
                        w_cache_wr     = 1'b1;
                        w_cache_sel    = 1'b1;
                        w_cache_offset = OFFW'(r_cnt - C_LAT);
                    end
                end
                S_CMP: begin
                    w_stall    = 1'b1;
                    w_comp     = 1'b1;
                    w_cache_wr = r_wr_q;
                end
                S_DONE: begin
                    w_done     = 1'b1;
                    w_comp     = 1'b1;
                    w_cache_wr = r_wr_q;
                end
                default: w_stall = 1'b1;
            endcase
        end
    end

    assign io_bus.stall        = w_stall;
    assign io_bus.done         = w_done;
    assign io_bus.err          = w_err;
    assign io_bus.cache_hit    = w_cache_hit;
    assign io_bus.cache_wr     = w_cache_wr;
    assign io_bus.comp         = w_comp;
    assign io_bus.cache_sel    = w_cache_sel;
    assign io_bus.cache_offset = w_cache_offset;
    assign io_bus.mem_wr       = w_mem_wr;
    assign io_bus.mem_rd       = w_mem_rd;
    assign io_bus.mem_sel      = w_mem_sel;
    assign io_bus.mem_offset   = w_mem_offset;
    assign o_dbg_state         = r_state;
endmodule
